// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: bus field positions, FSM/op encodings and bus pack/unpack helpers.
// Combinational helpers only; no latency or flow control of their own.
package mem_stage_pkg;

    localparam int BUS_W     = 58;
    localparam int INPORT_HI = 57;
    localparam int INPORT_LO = 42;
    localparam int DATA_HI   = 41;
    localparam int DATA_LO   = 26;
    localparam int ALU_HI    = 25;
    localparam int ALU_LO    = 10;
    localparam int RDST_HI   = 9;
    localparam int RDST_LO   = 7;
    localparam int MEMRD     = 6;
    localparam int MEMWR     = 5;
    localparam int PUSH      = 4;
    localparam int POP       = 3;
    localparam int INSIG     = 2;
    localparam int OUTSIG    = 1;
    localparam int WBEN      = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_READ,
        OP_WRITE,
        OP_PUSH,
        OP_POP
    } op_e;

    typedef struct packed {
        logic [15:0] inport;
        logic [15:0] data;
        logic [15:0] alu;
        logic [2:0]  rdst;
        logic        mem_read;
        logic        mem_write;
        logic        push;
        logic        pop;
        logic        in_sig;
        logic        out_sig;
        logic        wb_en;
    } mem_bus_t;

    function automatic mem_bus_t bus_unpack(input logic [BUS_W-1:0] v);
        mem_bus_t b;
        b.inport    = v[INPORT_HI:INPORT_LO];
        b.data      = v[DATA_HI:DATA_LO];
        b.alu       = v[ALU_HI:ALU_LO];
        b.rdst      = v[RDST_HI:RDST_LO];
        b.mem_read  = v[MEMRD];
        b.mem_write = v[MEMWR];
        b.push      = v[PUSH];
        b.pop       = v[POP];
        b.in_sig    = v[INSIG];
        b.out_sig   = v[OUTSIG];
        b.wb_en     = v[WBEN];
        return b;
    endfunction

    function automatic logic [BUS_W-1:0] bus_pack(input mem_bus_t b);
        logic [BUS_W-1:0] v;
        v                      = '0;
        v[INPORT_HI:INPORT_LO] = b.inport;
        v[DATA_HI:DATA_LO]     = b.data;
        v[ALU_HI:ALU_LO]       = b.alu;
        v[RDST_HI:RDST_LO]     = b.rdst;
        v[MEMRD]               = b.mem_read;
        v[MEMWR]               = b.mem_write;
        v[PUSH]                = b.push;
        v[POP]                 = b.pop;
        v[INSIG]               = b.in_sig;
        v[OUTSIG]              = b.out_sig;
        v[WBEN]                = b.wb_en;
        return v;
    endfunction

    // Several op bits may be set; only the highest-priority one executes.
    function automatic op_e op_decode(input mem_bus_t b);
        op_e op;
        if (b.pop)            op = OP_POP;
        else if (b.push)      op = OP_PUSH;
        else if (b.mem_read)  op = OP_READ;
        else if (b.mem_write) op = OP_WRITE;
        else                  op = OP_NONE;
        return op;
    endfunction

endpackage

// File: rtl/memory_stage_stack_pointer.sv
// Stack pointer register with +1 lookahead; updates one edge after upd, wrapping modulo 2^16.
// No backpressure: the owner strobes upd at most once per completed push/pop.
module stack_pointer #(
    parameter logic [15:0] SP_INIT = 16'h03FF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        upd,
    input  logic        dec,
    output logic [15:0] sp,
    output logic [15:0] sp_inc
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp <= SP_INIT;
        end else if (upd) begin
            sp <= dec ? sp - 16'd1 : sp + 16'd1;
        end
    end

    assign sp_inc = sp + 16'd1;

endmodule

// File: rtl/memory_stage.sv
// MEM stage: non-mem ops pass to MEM/WB in 1 cycle; loads/stores/push/pop go through a req/ack port with timeout.
// Stalls upstream while an access is outstanding; stall drops in the completing (ack or timeout) cycle.
module memory_stage
    import mem_stage_pkg::*;
#(
    parameter logic [15:0] SP_INIT  = 16'h03FF,
    parameter int          MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [BUS_W-1:0] ex_bus,
    input  logic [15:0]      mem_rdata,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic [15:0]      mem_addr,
    output logic [15:0]      mem_wdata,
    output logic             stall,
    output logic [BUS_W-1:0] Out,
    output logic [15:0]      sp,
    output logic             mem_err
);

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_e      state, state_nxt;
    mem_bus_t    in_b, lat_b, out_nxt;
    op_e         in_op, lat_op;
    logic [7:0]  wait_cnt;
    logic [15:0] sp_inc;
    logic        accept, ack_now, tmo_now, sp_upd, sp_dec;

    assign in_b   = bus_unpack(ex_bus);
    assign in_op  = op_decode(in_b);
    assign lat_op = op_decode(lat_b);

    stack_pointer #(.SP_INIT(SP_INIT)) u_sp (
        .clk    (clk),
        .rst    (rst),
        .upd    (sp_upd),
        .dec    (sp_dec),
        .sp     (sp),
        .sp_inc (sp_inc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid && in_op != OP_NONE) state_nxt = ST_WAIT;
            ST_WAIT: if (mem_ack || wait_cnt == WAIT_LAST) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The last timeout cycle releases stall so the next instruction lines up with the IDLE cycle.
    always_comb begin
        accept  = 1'b0;
        ack_now = 1'b0;
        tmo_now = 1'b0;
        stall   = 1'b0;
        case (state)
            ST_IDLE: begin
                accept = in_valid && (in_op != OP_NONE);
                stall  = accept;
            end
            ST_WAIT: begin
                ack_now = mem_ack;
                tmo_now = !mem_ack && (wait_cnt == WAIT_LAST);
                stall   = !ack_now && !tmo_now;
            end
            default: ;
        endcase
        sp_upd = ack_now && (lat_op == OP_PUSH || lat_op == OP_POP);
        sp_dec = (lat_op == OP_PUSH);
    end

    // Anything not producing a result is a bubble, which keeps out_sig low.
    always_comb begin
        out_nxt = '0;
        if (state == ST_IDLE && in_valid && in_op == OP_NONE) begin
            out_nxt      = in_b;
            out_nxt.data = '0;
        end else if (ack_now) begin
            out_nxt      = lat_b;
            out_nxt.data = (lat_op == OP_READ || lat_op == OP_POP) ? mem_rdata : 16'h0000;
        end else if (tmo_now) begin
            out_nxt         = lat_b;
            out_nxt.data    = '0;
            out_nxt.wb_en   = 1'b0;
            out_nxt.out_sig = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Out       <= '0;
            lat_b     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_err   <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            Out <= bus_pack(out_nxt);
            if (accept) begin
                lat_b    <= in_b;
                mem_req  <= 1'b1;
                wait_cnt <= '0;
                case (in_op)
                    OP_READ: begin
                        mem_addr <= in_b.alu;
                        mem_we   <= 1'b0;
                    end
                    OP_WRITE: begin
                        mem_addr  <= in_b.alu;
                        mem_we    <= 1'b1;
                        mem_wdata <= in_b.data;
                    end
                    OP_PUSH: begin
                        mem_addr  <= sp;
                        mem_we    <= 1'b1;
                        mem_wdata <= in_b.data;
                    end
                    default: begin
                        mem_addr <= sp_inc;
                        mem_we   <= 1'b0;
                    end
                endcase
            end else if (ack_now || tmo_now) begin
                mem_req <= 1'b0;
                if (tmo_now) mem_err <= 1'b1;
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

endmodule
